// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and default constants for the game-level sequencer
// Purpose: phase/difficulty/spawn-kind enums and the default enemy spawn periods (frames).
// Ports: none (package).
package game_pkg;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_COUNTDOWN = 2'd1,
    PH_PLAYING   = 2'd2,
    PH_OVER      = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'd0,
    DIFF_NORMAL = 2'd1,
    DIFF_HARD   = 2'd2
  } diff_t;

  typedef enum logic {
    KIND_ENEMY   = 1'b0,
    KIND_POWERUP = 1'b1
  } spawn_kind_t;

  localparam int DEF_EASY_PERIOD   = 180;
  localparam int DEF_NORMAL_PERIOD = 120;
  localparam int DEF_HARD_PERIOD   = 60;

endpackage

// File: rtl/slot_alloc.sv
// rtl/slot_alloc.sv - combinational lowest-index free slot finder
// Purpose: reports whether any slot is free and the index of the lowest free one.
// Ports:
//   busy  in  NUM_SLOTS  slot occupancy
//   found out 1          at least one slot is free
//   idx   out IDX_W      lowest free slot index (0 when none free)
module slot_alloc #(
  parameter int NUM_SLOTS = 4,
  localparam int IDX_W = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] busy,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - game phase sequencer and enemy/powerup spawn scheduler
// Purpose: runs IDLE/COUNTDOWN/PLAYING/OVER, times enemy and powerup spawns, and
// grants them round-robin into the lowest free object slot as a one-frame pulse.
// Optional: SPAWN_STATS_EN adds saturating drop counters enemy_drops / pwr_drops.
// Ports:
//   frame_clk, Reset_n                     frame clock, async active-low reset
//   easy/normal/hard_selected              menu selects (level)
//   game_over                              player dead (level)
//   lfsr_pos, lfsr_timer                   random spawn x / powerup reload sources
//   slot_release                           per-slot free pulse
//   phase, difficulty                      current phase and latched difficulty
//   spawn_valid, spawn_kind, spawn_slot, spawn_x   registered spawn pulse and payload
//   slot_busy, powerup_exists              occupancy and live-powerup flag
module spawn_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS        = 4,
  parameter int X_OFFSET         = 84,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int EASY_PERIOD      = DEF_EASY_PERIOD,
  parameter int NORMAL_PERIOD    = DEF_NORMAL_PERIOD,
  parameter int HARD_PERIOD      = DEF_HARD_PERIOD,
  localparam int IDX_W = $clog2(NUM_SLOTS)
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic                 easy_selected,
  input  logic                 normal_selected,
  input  logic                 hard_selected,
  input  logic                 game_over,
  input  logic [8:0]           lfsr_pos,
  input  logic [8:0]           lfsr_timer,
  input  logic [NUM_SLOTS-1:0] slot_release,
  output logic [1:0]           phase,
  output logic [1:0]           difficulty,
  output logic                 spawn_valid,
  output logic                 spawn_kind,
  output logic [IDX_W-1:0]     spawn_slot,
  output logic [9:0]           spawn_x,
  output logic [NUM_SLOTS-1:0] slot_busy,
`ifdef SPAWN_STATS_EN
  output logic [7:0]           enemy_drops,
  output logic [7:0]           pwr_drops,
`endif
  output logic                 powerup_exists
);

  localparam int CD_W = (COUNTDOWN_FRAMES > 1) ? $clog2(COUNTDOWN_FRAMES) : 1;
  localparam int ET_W = 8;

  phase_t                state, state_nxt;
  diff_t                 diff_q;
  logic [CD_W-1:0]       cd_cnt;
  logic [ET_W-1:0]       enemy_timer;
  logic [8:0]            pwr_timer;
  logic                  enemy_pend, pwr_pend;
  spawn_kind_t           last_kind, grant_kind;
  logic [NUM_SLOTS-1:0]  slot_kind, grant_mask;
  logic                  any_sel, grant, slot_found, e_exp, p_exp;
  logic [IDX_W-1:0]      free_idx;

  function automatic logic [ET_W-1:0] period_m1(input diff_t d);
    case (d)
      DIFF_HARD:   return ET_W'(HARD_PERIOD - 1);
      DIFF_NORMAL: return ET_W'(NORMAL_PERIOD - 1);
      default:     return ET_W'(EASY_PERIOD - 1);
    endcase
  endfunction

  slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .busy  (slot_busy),
    .found (slot_found),
    .idx   (free_idx)
  );

  assign any_sel        = easy_selected | normal_selected | hard_selected;
  assign powerup_exists = |(slot_busy & slot_kind);
  assign e_exp          = (enemy_timer == '0);
  assign p_exp          = (pwr_timer == '0);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= PH_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PH_IDLE:      if (any_sel)        state_nxt = PH_COUNTDOWN;
      PH_COUNTDOWN: if (cd_cnt == '0)   state_nxt = PH_PLAYING;
      PH_PLAYING:   if (game_over)      state_nxt = PH_OVER;
      PH_OVER:      if (!any_sel)       state_nxt = PH_IDLE;
      default:                          state_nxt = PH_IDLE;
    endcase
  end

  // Grant is decided from registered state only; game_over suppresses it on the exit edge.
  always_comb begin
    phase      = state;
    difficulty = diff_q;
    grant      = (state == PH_PLAYING) && !game_over && slot_found && (enemy_pend || pwr_pend);
    if (enemy_pend && pwr_pend)
      grant_kind = (last_kind == KIND_ENEMY) ? KIND_POWERUP : KIND_ENEMY;
    else
      grant_kind = pwr_pend ? KIND_POWERUP : KIND_ENEMY;
    grant_mask = grant ? (NUM_SLOTS'(1) << free_idx) : '0;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      diff_q      <= DIFF_EASY;
      cd_cnt      <= '0;
      enemy_timer <= '0;
      pwr_timer   <= '0;
      enemy_pend  <= 1'b0;
      pwr_pend    <= 1'b0;
      last_kind   <= KIND_POWERUP;
      slot_busy   <= '0;
      slot_kind   <= '0;
      spawn_valid <= 1'b0;
      spawn_kind  <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
    end else begin
      spawn_valid <= grant;
      slot_busy   <= (slot_busy & ~slot_release) | grant_mask;
      if (grant) begin
        spawn_kind           <= grant_kind;
        spawn_slot           <= free_idx;
        spawn_x              <= {1'b0, lfsr_pos} + 10'(X_OFFSET);
        last_kind            <= grant_kind;
        slot_kind[free_idx]  <= grant_kind;
      end
      case (state)
        PH_IDLE: begin
          if (any_sel) begin
            diff_q <= hard_selected ? DIFF_HARD : (normal_selected ? DIFF_NORMAL : DIFF_EASY);
            cd_cnt <= CD_W'(COUNTDOWN_FRAMES - 1);
          end
        end
        PH_COUNTDOWN: begin
          if (cd_cnt == '0) begin
            enemy_timer <= period_m1(diff_q);
            pwr_timer   <= 9'd511;
          end else begin
            cd_cnt <= cd_cnt - CD_W'(1);
          end
        end
        PH_PLAYING: begin
          if (game_over) begin
            enemy_pend <= 1'b0;
            pwr_pend   <= 1'b0;
          end else begin
            enemy_timer <= e_exp ? period_m1(diff_q) : enemy_timer - ET_W'(1);
            pwr_timer   <= p_exp ? lfsr_timer : pwr_timer - 9'd1;
            // Clear-on-grant first so a same-edge expiry re-arms the flag.
            if (grant && grant_kind == KIND_ENEMY)   enemy_pend <= 1'b0;
            if (grant && grant_kind == KIND_POWERUP) pwr_pend   <= 1'b0;
            if (e_exp)                                enemy_pend <= 1'b1;
            if (p_exp && !powerup_exists && !pwr_pend) pwr_pend  <= 1'b1;
          end
        end
        PH_OVER: begin
          enemy_pend <= 1'b0;
          pwr_pend   <= 1'b0;
          if (!any_sel) begin
            slot_busy <= '0;
            slot_kind <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPAWN_STATS_EN
  // A drop is an expiry that finds its flag still set and not being granted this edge.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      enemy_drops <= '0;
      pwr_drops   <= '0;
    end else if (state == PH_IDLE && any_sel) begin
      enemy_drops <= '0;
      pwr_drops   <= '0;
    end else if (state == PH_PLAYING && !game_over) begin
      if (e_exp && enemy_pend && !(grant && grant_kind == KIND_ENEMY) && enemy_drops != 8'hFF)
        enemy_drops <= enemy_drops + 8'd1;
      if (p_exp && pwr_pend && !(grant && grant_kind == KIND_POWERUP) && pwr_drops != 8'hFF)
        pwr_drops <= pwr_drops + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - scoreboard bench for spawn_scheduler
module tb_spawn_scheduler;
  import game_pkg::*;

  localparam int NS = 4;

  logic          frame_clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          easy_selected = 1'b0, normal_selected = 1'b0, hard_selected = 1'b0;
  logic          game_over = 1'b0;
  logic [8:0]    lfsr_pos = '0, lfsr_timer = '0;
  logic [NS-1:0] slot_release = '0;
  logic [1:0]    phase, difficulty;
  logic          spawn_valid, spawn_kind, powerup_exists;
  logic [1:0]    spawn_slot;
  logic [9:0]    spawn_x;
  logic [NS-1:0] slot_busy;
`ifdef SPAWN_STATS_EN
  logic [7:0]    enemy_drops, pwr_drops;
`endif

  spawn_scheduler #(.NUM_SLOTS(NS)) dut (
    .frame_clk       (frame_clk),
    .Reset_n         (Reset_n),
    .easy_selected   (easy_selected),
    .normal_selected (normal_selected),
    .hard_selected   (hard_selected),
    .game_over       (game_over),
    .lfsr_pos        (lfsr_pos),
    .lfsr_timer      (lfsr_timer),
    .slot_release    (slot_release),
    .phase           (phase),
    .difficulty      (difficulty),
    .spawn_valid     (spawn_valid),
    .spawn_kind      (spawn_kind),
    .spawn_slot      (spawn_slot),
    .spawn_x         (spawn_x),
    .slot_busy       (slot_busy),
`ifdef SPAWN_STATS_EN
    .enemy_drops     (enemy_drops),
    .pwr_drops       (pwr_drops),
`endif
    .powerup_exists  (powerup_exists)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0;
  int checks = 0;
  int frame  = 0;
  int t0     = 0;
  int n_cd;

  typedef struct {
    int t;
    int kind;
    int slot;
    int x;
  } spawn_exp_t;
  spawn_exp_t sb[$];

  always @(posedge frame_clk) frame <= frame + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int t, input int kind, input int slot, input int x);
    spawn_exp_t e;
    e.t = t; e.kind = kind; e.slot = slot; e.x = x;
    sb.push_back(e);
  endtask

  // Lands on the negedge of frame t (relative to PLAYING entry); inputs set here apply at edge t+1.
  task automatic to_t(input int tt);
    int guard = 0;
    while ((frame - t0) < tt && guard < 5000) begin
      @(negedge frame_clk);
      guard++;
    end
  endtask

  task automatic release_at(input logic [NS-1:0] mask, input int edge_t);
    to_t(edge_t - 1);
    slot_release = mask;
    to_t(edge_t);
    slot_release = '0;
  endtask

  task automatic run_countdown(output int n);
    n = 0;
    while (phase == 2'd1 && n < 300) begin
      n++;
      @(negedge frame_clk);
    end
  endtask

  always @(negedge frame_clk) begin
    if (Reset_n && spawn_valid) begin
      if (sb.size() == 0) begin
        check("spurious_spawn", spawn_valid, 1'b0);
      end else begin
        spawn_exp_t e;
        e = sb.pop_front();
        check("spawn_t", frame - t0, e.t);
        check("spawn_kind", spawn_kind, e.kind);
        check("spawn_slot", spawn_slot, e.slot);
        check("spawn_x", spawn_x, e.x);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_phase", phase, 0);
    check("rst_difficulty", difficulty, 0);
    check("rst_spawn_valid", spawn_valid, 0);
    check("rst_slot_busy", slot_busy, 0);
    check("rst_spawn_x", spawn_x, 0);
    check("rst_powerup_exists", powerup_exists, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge frame_clk);
    check("idle_hold_phase", phase, 0);

    // Game A: normal difficulty, lfsr_pos=16 -> x=100
    lfsr_pos = 9'd16;
    lfsr_timer = 9'd500;
    normal_selected = 1'b1;
    @(negedge frame_clk);
    normal_selected = 1'b0;
    run_countdown(n_cd);
    check("countdown_frames", n_cd, 120);
    check("play_phase", phase, 2);
    check("play_difficulty", difficulty, 1);
    t0 = frame;
    push(121, 0, 0, 100);
    push(241, 0, 1, 100);
    push(361, 0, 2, 100);
    push(481, 0, 3, 100);
    push(731, 1, 2, 100);
    push(741, 0, 0, 100);
    push(1021, 0, 2, 100);
    push(1064, 1, 1, 100);
    push(1101, 0, 1, 100);
    push(1201, 1, 0, 100);
    push(1202, 0, 3, 100);

    to_t(122);
    check("first_busy", slot_busy, 4'b0001);
    to_t(725);
    check("full_busy", slot_busy, 4'hF);
`ifdef SPAWN_STATS_EN
    check("enemy_drops_1", enemy_drops, 1);
`endif
    release_at(4'b0100, 730);
    to_t(732);
    check("pwr_exists_a", powerup_exists, 1);
    release_at(4'b0001, 740);
    to_t(1000);
    lfsr_timer = 9'd49;
`ifdef SPAWN_STATS_EN
    check("enemy_drops_2", enemy_drops, 2);
`endif
    to_t(1014);
    check("busy_at_pwr_blocked", slot_busy, 4'hF);
`ifdef SPAWN_STATS_EN
    check("pwr_drops_0", pwr_drops, 0);
`endif
    release_at(4'b0100, 1020);
    check("pwr_gone", powerup_exists, 0);
    release_at(4'b0010, 1030);
    lfsr_timer = 9'd136;
    to_t(1065);
    check("pwr_exists_b", powerup_exists, 1);
    release_at(4'b0010, 1100);
    release_at(4'b1001, 1150);
    lfsr_timer = 9'd511;
    to_t(1203);
    check("pwr_exists_tie", powerup_exists, 1);
    check("busy_after_tie", slot_busy, 4'hF);

    // game_over with an enemy pending and slot 3 just freed: no grant on the exit edge
    release_at(4'b1000, 1320);
    game_over = 1'b1;
    easy_selected = 1'b1;
    to_t(1321);
    check("over_phase", phase, 3);
    check("over_busy", slot_busy, 4'b0111);
    to_t(1324);
    check("over_hold_phase", phase, 3);
    game_over = 1'b0;
    easy_selected = 1'b0;
    to_t(1325);
    check("back_idle_phase", phase, 0);
    check("back_idle_busy", slot_busy, 0);
    check("back_idle_diff", difficulty, 1);
    check("sb_empty_a", sb.size(), 0);

    // Game B: hard beats normal, x at maximum 511+84=595, then async reset mid-play
    lfsr_pos = 9'd511;
    hard_selected = 1'b1;
    normal_selected = 1'b1;
    @(negedge frame_clk);
    hard_selected = 1'b0;
    normal_selected = 1'b0;
`ifdef SPAWN_STATS_EN
    check("drops_cleared", enemy_drops, 0);
`endif
    run_countdown(n_cd);
    check("countdown_frames_b", n_cd, 120);
    check("hard_difficulty", difficulty, 2);
    t0 = frame;
    push(61, 0, 0, 595);
    to_t(62);
    check("hard_busy", slot_busy, 4'b0001);
    to_t(70);
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_phase", phase, 0);
    check("arst_difficulty", difficulty, 0);
    check("arst_busy", slot_busy, 0);
    check("arst_spawn_x", spawn_x, 0);
    check("arst_spawn_slot", spawn_slot, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge frame_clk);
    check("post_rst_phase", phase, 0);
    check("sb_empty_b", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
